// File: rtl/mvu_pe_acc_multi.sv
// -----------------------------------------------------------------------------
// mvu_pe_acc_multi
//
// Multi-lane PE accumulator for the matrix-vector unit. PE independent lanes
// each accumulate TI-bit partial sums into TDstI-bit accumulators across one
// row fold. The row result is presented on a single-entry valid/ready output
// register. The control strobes are delayed by PIPE_DLY cycles so that they
// line up with in_acc, which arrives that many cycles after its control.
//
// Ports:
//   aclk            clock
//   aresetn         synchronous, active-low reset
//   do_mvau_stream  control: a beat of partial sums is in flight
//   sf_clr          control: this beat closes the row fold
//   in_acc          PE packed TI-bit lane inputs, lane i at [i*TI +: TI]
//   out_acc_rdy     downstream ready
//   out_acc_v       output valid
//   out_acc         PE packed TDstI-bit lane results
//   overrun         sticky: a completed row was dropped (output held, not ready)
//   ovf             sticky per-lane saturation flag
//
// Build option:
//   SATURATE_EN  when defined, each lane add clamps to the representable range
//                and sets that lane's ovf bit; otherwise arithmetic wraps
//                modulo 2^TDstI and ovf stays 0.
// -----------------------------------------------------------------------------
module mvu_pe_acc_multi #(
  parameter int PE       = 4,
  parameter int TI       = 8,
  parameter int TDstI    = 16,
  parameter int PIPE_DLY = 2,
  parameter int SIGNED   = 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  do_mvau_stream,
  input  logic                  sf_clr,
  input  logic [PE*TI-1:0]      in_acc,
  input  logic                  out_acc_rdy,
  output logic                  out_acc_v,
  output logic [PE*TDstI-1:0]   out_acc,
  output logic                  overrun,
  output logic [PE-1:0]         ovf
);

  // Widen one lane input to accumulator width.
  function automatic logic [TDstI-1:0] ext_lane(input logic [TI-1:0] x);
    if (SIGNED != 0) return TDstI'($signed(x));
    else             return TDstI'(x);
  endfunction

  // Lane add; returns {clamped, result}. Without saturation the result is the
  // plain modulo sum and the clamp flag is always 0.
  function automatic logic [TDstI:0] acc_add(input logic [TDstI-1:0] a,
                                             input logic [TDstI-1:0] b);
    logic [TDstI:0]   wide;
    logic [TDstI-1:0] res;
    logic             clamp;
`ifdef SATURATE_EN
    logic [TDstI-1:0] smax;
`endif
    if (SIGNED != 0) begin
      wide  = {a[TDstI-1], a} + {b[TDstI-1], b};
      // Signed overflow: the extra sign bit disagrees with the result sign.
      clamp = wide[TDstI] ^ wide[TDstI-1];
    end else begin
      wide  = {1'b0, a} + {1'b0, b};
      clamp = wide[TDstI];
    end
    res = wide[TDstI-1:0];
`ifdef SATURATE_EN
    smax = {TDstI{1'b1}} >> 1;
    if (clamp) begin
      if (SIGNED != 0) res = wide[TDstI] ? ~smax : smax;
      else             res = '1;
    end
`else
    clamp = 1'b0;
`endif
    return {clamp, res};
  endfunction

  logic vld_d;
  logic last_d;

  // ---- stage p0: control delay line aligning strobes with in_acc ----
  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign vld_d  = do_mvau_stream;
      assign last_d = sf_clr;
    end else begin : g_dly
      logic [PIPE_DLY-1:0] vld_sr;
      logic [PIPE_DLY-1:0] last_sr;

      always_ff @(posedge aclk) begin
        if (!aresetn) begin
          vld_sr  <= '0;
          last_sr <= '0;
        end else begin
          vld_sr[0]  <= do_mvau_stream;
          last_sr[0] <= sf_clr;
          for (int i = 1; i < PIPE_DLY; i++) begin
            vld_sr[i]  <= vld_sr[i-1];
            last_sr[i] <= last_sr[i-1];
          end
        end
      end

      assign vld_d  = vld_sr[PIPE_DLY-1];
      assign last_d = last_sr[PIPE_DLY-1];
    end
  endgenerate

  logic [TDstI-1:0] acc_p0 [PE];
  logic [TDstI-1:0] sum_c  [PE];
  logic [PE-1:0]    clamp_c;
  logic [PE-1:0]    ovf_q;
  logic             done;

  always_comb begin
    clamp_c = '0;
    for (int i = 0; i < PE; i++) begin
      sum_c[i] = '0;
      {clamp_c[i], sum_c[i]} = acc_add(acc_p0[i], ext_lane(in_acc[i*TI +: TI]));
    end
  end

  assign done = vld_d & last_d;

  // ---- stage p1: accumulators and the single-entry output register ----
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < PE; i++) acc_p0[i] <= '0;
      out_acc_v <= 1'b0;
      out_acc   <= '0;
      overrun   <= 1'b0;
      ovf_q     <= '0;
    end else begin
      // last_d clears the lane whether or not the beat is valid, so a
      // last-without-valid strobe flushes a partial row without a result.
      for (int i = 0; i < PE; i++) begin
        if (last_d)     acc_p0[i] <= '0;
        else if (vld_d) acc_p0[i] <= sum_c[i];
      end

      if (vld_d) ovf_q <= ovf_q | clamp_c;

      if (done && (!out_acc_v || out_acc_rdy)) begin
        out_acc_v <= 1'b1;
        for (int i = 0; i < PE; i++) out_acc[i*TDstI +: TDstI] <= sum_c[i];
      end else if (done) begin
        // Held entry not yet taken: keep it and drop the new row.
        overrun <= 1'b1;
      end else if (out_acc_rdy) begin
        out_acc_v <= 1'b0;
      end
    end
  end

  assign ovf = ovf_q;

endmodule
